mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: WORD_AW, 8, RAM word-index width; mem_addr bits above WORD_AW-1 driven 0.
REQ-002 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req  input  1  CPU access request, accepted only when ready=1.
REQ-005 SHALL have port: op  input  3  mem_op_t (LB, LBU, LH, LHU, LW, SB, SH, SW).
REQ-006 SHALL have port: addr  input  32  byte address.
REQ-007 SHALL have port: wdata  input  32  store data, right-justified.
REQ-008 SHALL have port: ready  output  1  idle, can accept req.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: rdata  output  32  extended load result, valid while done=1.
REQ-011 SHALL have port: err  output  1  misaligned access flag, valid while done=1.
REQ-012 SHALL have ports to word RAM: mem_addr output 32 word index; mem_wdata output 32; mem_read output 1; mem_write output 1; mem_rdata input 32, sampled only when mem_read=1.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP; ready=1 only in IDLE.
REQ-014 SHALL capture op, addr, wdata on rising edge with req=1 in IDLE; req outside IDLE ignored.
REQ-015 SHALL drive mem_addr = addr[WORD_AW+1:2], registered at acceptance, held until next acceptance.
REQ-016 Loads: IDLE->LOAD (mem_read=1, mem_rdata registered at end of cycle)->RESP; done two cycles after acceptance edge.
REQ-017 SW: IDLE->STORE (mem_write=1, mem_wdata=wdata for whole cycle; RAM commits on falling edge)->RESP.
REQ-018 SB/SH: IDLE->RMW_RD (mem_read=1, word captured)->RMW_WR (mem_write=1, merged word)->RESP; done three cycles after acceptance.
REQ-019 SHALL use little-endian lanes: byte k = bits 8k+7:8k, k=addr[1:0]; halfword at addr[1]=0 is bits 15:0, addr[1]=1 is bits 31:16.
REQ-020 Merge SHALL replace only addressed lane with wdata[7:0] (SB) or wdata[15:0] (SH); other lanes unchanged.
REQ-021 LB/LH SHALL sign-extend to 32 bits; LBU/LHU zero-extend; LW unchanged.
REQ-022 RESP SHALL assert done=1 one cycle, then IDLE; rdata=0 for stores; rdata and err held until next done.
REQ-023 mem_read and mem_write SHALL never be asserted together; both 0 in IDLE and RESP.
REQ-024 Back-to-back: req asserted in the cycle after RESP SHALL be accepted.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, ready=1, done=0, err=0, rdata=0, mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0.
REQ-026 Reset mid-operation SHALL abort it with no done pulse; mem_write drops immediately, so no RAM write follows the reset assertion.

Configuration
REQ-027 With MEM_ACCESS_MISALIGN_EXC_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL go IDLE->RESP with no memory strobe, done=1, err=1, rdata=0.
REQ-028 Without MEM_ACCESS_MISALIGN_EXC_EN: misalignment bits SHALL be ignored (access forced to aligned lane/word), err tied 0.

Structure
REQ-029 mem_op_t enum, FSM state typedef and lane-select constants SHALL live in shared package mem_pkg.
REQ-030 Lane extraction and sign/zero extension SHALL be one combinational sub-module, load_extend.

Verification
REQ-031 RAM word 5 = 0x8899AABB; LB addr 0x15 -> done at cycle 2, rdata=0xFFFFFFAA, err=0.
REQ-032 Same word; LHU addr 0x16 -> rdata=0x00008899; LH addr 0x16 -> rdata=0xFFFF8899.
REQ-033 SB addr 0x17 wdata 0x12345677 -> RMW, done at cycle 3, word 5 = 0x7799AABB; following LW addr 0x14 -> 0x7799AABB.
REQ-034 SW addr 0x20 wdata 0xDEADBEEF then SH addr 0x20 wdata 0x0000CAFE -> word 8 = 0xDEADCAFE; req held high throughout -> each accepted only when ready=1.
REQ-035 LW addr 0x22: with macro -> done cycle 1, err=1, no mem_read; without macro -> reads word 8, err=0.
REQ-036 rst_n pulled low during RMW_WR of SB -> mem_write drops at once, RAM word unchanged, ready=1, no done.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory access unit: access opcodes, FSM states,
// lane-select constants and the store-merge / alignment helpers.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;
  localparam logic       HALF_LO = 1'b0;
  localparam logic       HALF_HI = 1'b1;

  function automatic logic is_load(input mem_op_t op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic misaligned(input mem_op_t op, input logic [1:0] lane);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: hit = lane[0];
      OP_LW, OP_SW:         hit = |lane;
      default:              hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Replace only the addressed byte (SB) or halfword (SH); other lanes pass through.
  function automatic logic [31:0] merge_store(input mem_op_t op, input logic [1:0] lane,
                                              input logic [31:0] word, input logic [15:0] data);
    logic [31:0] res;
    res = word;
    if (op == OP_SB) begin
      case (lane)
        LANE_B0: res[7:0]   = data[7:0];
        LANE_B1: res[15:8]  = data[7:0];
        LANE_B2: res[23:16] = data[7:0];
        default: res[31:24] = data[7:0];
      endcase
    end else if (lane[1] == HALF_HI) begin
      res[31:16] = data;
    end else begin
      res[15:0] = data;
    end
    return res;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a RAM word and sign- or
// zero-extends it according to the load opcode; stores yield zero.
module load_extend
  import mem_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      LANE_B0: byte_sel = word[7:0];
      LANE_B1: byte_sel = word[15:8];
      LANE_B2: byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = (lane[1] == HALF_HI) ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = '0;
    case (op)
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'd0, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'd0, half_sel};
      OP_LW:   result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store unit in front of a word-wide RAM, using
// read-modify-write for sub-word stores. Define MEM_ACCESS_MISALIGN_EXC_EN
// to flag misaligned accesses with err instead of forcing them aligned.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int WORD_AW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  mem_op_t     op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output state_t      state
);

  // Request handshake: a request is taken on the rising edge where req=1 and
  // ready=1; while ready=0 the request inputs are ignored entirely.

  mem_op_t              op_q;
  logic [1:0]           lane_q;
  logic [15:0]          wdata_q;
  logic [WORD_AW-1:0]   word_q;
  logic [31:0]          ext_data;
  logic                 misalign;
  logic                 unused_addr_hi;

  assign mem_addr       = {{(32 - WORD_AW){1'b0}}, word_q};
  assign unused_addr_hi = ^addr[31:WORD_AW+2];

`ifdef MEM_ACCESS_MISALIGN_EXC_EN
  assign misalign = misaligned(op, addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  load_extend u_load_extend (
    .op     (op_q),
    .lane   (lane_q),
    .word   (mem_rdata),
    .result (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      word_q    <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      op_q      <= OP_LB;
      lane_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_q    <= op;
            lane_q  <= addr[1:0];
            wdata_q <= wdata[15:0];
            word_q  <= addr[WORD_AW+1:2];
            ready   <= 1'b0;
            if (misalign) begin
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end else if (is_load(op)) begin
              state    <= LOAD;
              mem_read <= 1'b1;
            end else if (op == OP_SW) begin
              state     <= STORE;
              mem_write <= 1'b1;
              mem_wdata <= wdata;
            end else begin
              state    <= RMW_RD;
              mem_read <= 1'b1;
            end
          end
        end
        LOAD: begin
          mem_read <= 1'b0;
          rdata    <= ext_data;
          err      <= 1'b0;
          done     <= 1'b1;
          state    <= RESP;
        end
        STORE, RMW_WR: begin
          mem_write <= 1'b0;
          rdata     <= '0;
          err       <= 1'b0;
          done      <= 1'b1;
          state     <= RESP;
        end
        RMW_RD: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b1;
          mem_wdata <= merge_store(op_q, lane_q, mem_rdata, wdata_q);
          state     <= RMW_WR;
        end
        RESP: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          done      <= 1'b0;
          ready     <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word RAM that
// commits writes on the falling edge.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  mem_op_t     op = OP_LB;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, err, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  state_t      dut_state;

  logic [31:0] ram [0:255];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.WORD_AW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .state     (dut_state)
  );

  assign mem_rdata = ram[mem_addr[7:0]];

  always @(negedge clk) begin
    if (mem_write) ram[mem_addr[7:0]] = mem_wdata;
  end

  task automatic run_op(input mem_op_t o, input logic [31:0] a, input logic [31:0] wd,
                        input int exp_cyc, input logic [31:0] exp_rd, input logic exp_err,
                        input string name, output logic saw_rd, output logic saw_wr);
    int   cyc;
    logic overlap;
    logic rdy_at_done;
    logic [31:0] exp_maddr;
    cyc = 0; overlap = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0; rdy_at_done = 1'b1;
    exp_maddr = {24'd0, a[9:2]};
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    for (int n = 1; n <= 8 && cyc == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        vectors++;
        if (mem_addr !== exp_maddr) begin
          miscompares++;
          $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, exp_maddr);
        end
      end
      saw_rd |= mem_read;
      saw_wr |= mem_write;
      if (mem_read && mem_write) overlap = 1'b1;
      if (done === 1'b1) begin
        cyc = n;
        rdy_at_done = ready;
      end
    end
    vectors++;
    if (cyc != exp_cyc) begin
      miscompares++;
      $display("FAIL %s done_cycle: got %0d want %0d (0 = no done)", name, cyc, exp_cyc);
    end
    vectors++;
    if (rdata !== exp_rd) begin
      miscompares++;
      $display("FAIL %s rdata: got %h want %h", name, rdata, exp_rd);
    end
    vectors++;
    if (err !== exp_err) begin
      miscompares++;
      $display("FAIL %s err: got %b want %b", name, err, exp_err);
    end
    vectors++;
    if (overlap !== 1'b0 || rdy_at_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s strobes: overlap %b ready_at_done %b want 0 0", name, overlap, rdy_at_done);
    end
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_resp: ready %b done %b want 1 0", name, ready, done);
    end
  endtask

  task automatic check_word(input int idx, input logic [31:0] exp, input string name);
    vectors++;
    if (ram[idx] !== exp) begin
      miscompares++;
      $display("FAIL %s ram[%0d]: got %h want %h", name, idx, ram[idx], exp);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_status: ready %b done %b err %b rdata %h want 1 0 0 0", ready, done, err, rdata);
    end
    vectors++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mem: addr %h wdata %h rd %b wr %b want 0 0 0 0", mem_addr, mem_wdata, mem_read, mem_write);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loads;
    logic r, w;
    run_op(OP_LB,  32'h15, 32'd0, 2, 32'hFFFFFFAA, 1'b0, "lb_15", r, w);
    run_op(OP_LHU, 32'h16, 32'd0, 2, 32'h00008899, 1'b0, "lhu_16", r, w);
    run_op(OP_LH,  32'h16, 32'd0, 2, 32'hFFFF8899, 1'b0, "lh_16", r, w);
    run_op(OP_LH,  32'h14, 32'd0, 2, 32'hFFFFAABB, 1'b0, "lh_14", r, w);
    run_op(OP_LBU, 32'h17, 32'd0, 2, 32'h00000088, 1'b0, "lbu_17", r, w);
    run_op(OP_LB,  32'h14, 32'd0, 2, 32'hFFFFFFBB, 1'b0, "lb_14", r, w);
    run_op(OP_LW,  32'h14, 32'd0, 2, 32'h8899AABB, 1'b0, "lw_14", r, w);
    run_op(OP_LB,  32'h19, 32'd0, 2, 32'h00000050, 1'b0, "lb_19", r, w);
    run_op(OP_LH,  32'h1A, 32'd0, 2, 32'h00007F01, 1'b0, "lh_1a", r, w);
    vectors++;
    if (w !== 1'b0 || r !== 1'b1) begin
      miscompares++;
      $display("FAIL load_strobes: saw_read %b saw_write %b want 1 0", r, w);
    end
  endtask

  task automatic test_rmw;
    logic r, w;
    run_op(OP_SB, 32'h17, 32'h12345677, 3, 32'd0, 1'b0, "sb_17", r, w);
    check_word(5, 32'h7799AABB, "sb_17");
    run_op(OP_LW, 32'h14, 32'd0, 2, 32'h7799AABB, 1'b0, "lw_after_sb", r, w);
    run_op(OP_SH, 32'h16, 32'hFFFF0102, 3, 32'd0, 1'b0, "sh_16", r, w);
    check_word(5, 32'h0102AABB, "sh_16");
    run_op(OP_SB, 32'h15, 32'h0000005A, 3, 32'd0, 1'b0, "sb_15", r, w);
    check_word(5, 32'h01025ABB, "sb_15");
  endtask

  task automatic test_back_to_back;
    int first, second;
    logic [5:0] rdy_mask;
    first = 0; second = 0; rdy_mask = '0;
    @(negedge clk);
    req = 1'b1; op = OP_SW; addr = 32'h20; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 op = OP_SH; wdata = 32'h0000CAFE;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n <= 6) rdy_mask[n-1] = ready;
      if (done === 1'b1) begin
        if (first == 0) first = n;
        else if (second == 0) second = n;
      end
      if (n == 4) req = 1'b0;
    end
    vectors++;
    if (first != 2 || second != 6) begin
      miscompares++;
      $display("FAIL b2b_done: cycles %0d %0d want 2 6", first, second);
    end
    vectors++;
    if (rdy_mask !== 6'b000100) begin
      miscompares++;
      $display("FAIL b2b_ready: mask %b want 000100", rdy_mask);
    end
    check_word(8, 32'hDEADCAFE, "b2b");
  endtask

  task automatic test_misalign;
    logic r, w;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
    run_op(OP_LW, 32'h22, 32'd0, 1, 32'd0, 1'b1, "lw_22", r, w);
    vectors++;
    if (r !== 1'b0 || w !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_22_strobe: read %b write %b want 0 0", r, w);
    end
    run_op(OP_LHU, 32'h23, 32'd0, 1, 32'd0, 1'b1, "lhu_23", r, w);
    run_op(OP_SH, 32'h21, 32'h0000BEEF, 1, 32'd0, 1'b1, "sh_21", r, w);
    check_word(8, 32'hDEADCAFE, "sh_21");
`else
    run_op(OP_LW, 32'h22, 32'd0, 2, 32'hDEADCAFE, 1'b0, "lw_22", r, w);
    vectors++;
    if (r !== 1'b1) begin
      miscompares++;
      $display("FAIL lw_22_strobe: read %b want 1", r);
    end
    run_op(OP_LHU, 32'h23, 32'd0, 2, 32'h0000DEAD, 1'b0, "lhu_23", r, w);
    run_op(OP_SH, 32'h21, 32'h0000BEEF, 3, 32'd0, 1'b0, "sh_21", r, w);
    check_word(8, 32'hDEADBEEF, "sh_21");
`endif
  endtask

  task automatic test_reset_mid;
    logic saw_done;
    logic r, w;
    saw_done = 1'b0;
    @(negedge clk);
    req = 1'b1; op = OP_SB; addr = 32'h24; wdata = 32'h00000055;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_write !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_now: write %b ready %b done %b want 0 1 0", mem_write, ready, done);
    end
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_after: saw_done %b ready %b want 0 1", saw_done, ready);
    end
    check_word(9, 32'h11223344, "reset_mid");
    run_op(OP_LW, 32'h24, 32'd0, 2, 32'h11223344, 1'b0, "lw_after_reset", r, w);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    ram[5] = 32'h8899AABB;
    ram[6] = 32'h7F0150AA;
    ram[9] = 32'h11223344;
    test_reset;
    test_loads;
    test_rmw;
    test_back_to_back;
    test_misalign;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
